// File: rtl/ipc_pkg.sv
// Shared header layout and helper functions for the parametrised input port cluster.
// Functions take field widths as arguments so one package serves every instantiation.
package ipc_pkg;

  localparam int DEF_PACKET_BITS   = 97;
  localparam int DEF_NUM_LEAF_BITS = 6;
  localparam int DEF_NUM_PORT_BITS = 4;
  localparam int VLD_BIT           = DEF_PACKET_BITS - 1;
  localparam int LEAF_LSB          = VLD_BIT - DEF_NUM_LEAF_BITS;
  localparam int PORT_LSB          = LEAF_LSB - DEF_NUM_PORT_BITS;

  localparam int MAX_PKT_W   = 256;
  localparam int MAX_FIELD_W = 16;
  localparam int MAX_CNT_W   = 64;

  typedef logic [MAX_PKT_W-1:0] pkt_max_t;
  typedef logic [MAX_CNT_W-1:0] cnt_max_t;

  function automatic pkt_max_t low_mask(input int w);
    return (pkt_max_t'(1) << w) - pkt_max_t'(1);
  endfunction

  // Valid bit on top, then leaf, then port; payload right-aligned, gap bits zero.
  function automatic pkt_max_t build_credit(input int pkt_w, input int leaf_w, input int port_w,
                                            input int pay_w,
                                            input logic [MAX_FIELD_W-1:0] leaf,
                                            input logic [MAX_FIELD_W-1:0] port,
                                            input cnt_max_t payload);
    pkt_max_t p;
    p = pkt_max_t'(1) << (pkt_w - 1);
    p = p | ((pkt_max_t'(leaf) & low_mask(leaf_w)) << (pkt_w - 1 - leaf_w));
    p = p | ((pkt_max_t'(port) & low_mask(port_w)) << (pkt_w - 1 - leaf_w - port_w));
    p = p | (pkt_max_t'(payload) & low_mask(pay_w));
    return p;
  endfunction

  function automatic cnt_max_t sat_inc(input cnt_max_t v, input int w);
    cnt_max_t maxv;
    maxv = (w >= MAX_CNT_W) ? '1 : ((cnt_max_t'(1) << w) - cnt_max_t'(1));
    return (v == maxv) ? v : v + cnt_max_t'(1);
  endfunction

endpackage

// File: rtl/input_port_cluster_param_if.sv
// User-side FIFO head handshake: per-channel data, valid and pop acknowledge.
interface input_port_cluster_param_if #(
  parameter int N      = 7,
  parameter int USER_W = 32
);
  logic [USER_W*N-1:0] dout2user;
  logic [N-1:0]        vld2user;
  logic [N-1:0]        ack_user2b_in;

  modport master (output dout2user, output vld2user, input ack_user2b_in);
  modport slave  (input dout2user, input vld2user, output ack_user2b_in);
endinterface

// File: rtl/ipc_port_fifo.sv
// First-word-fall-through FIFO: head is readable the cycle after it is written.
// Storage is not reset; only pointers and flags are.
module ipc_port_fifo #(
  parameter int W          = 32,
  parameter int DEPTH_BITS = 7
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_en,
  input  logic [W-1:0]        wr_data,
  input  logic                rd_en,
  output logic [W-1:0]        rd_data,
  output logic                full,
  output logic                empty,
  output logic [DEPTH_BITS:0] count
);
  localparam int D   = 1 << DEPTH_BITS;
  localparam int CNW = DEPTH_BITS + 1;

  logic [W-1:0]            mem [D];
  logic [DEPTH_BITS-1:0]   wr_ptr, rd_ptr;
  logic                    do_wr, do_rd;

  assign do_wr   = wr_en && !full;
  assign do_rd   = rd_en && !empty;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10: begin
          count <= count + 1'b1;
          full  <= (count == CNW'(D - 1));
          empty <= 1'b0;
        end
        2'b01: begin
          count <= count - 1'b1;
          full  <= 1'b0;
          empty <= (count == CNW'(1));
        end
        default: ;
      endcase
    end
  end
endmodule

// File: rtl/input_port_cluster_param.sv
// Leaf NoC input cluster: demuxes packets into per-channel FIFOs, returns freespace
// credits upstream every FREESPACE_UPDATE_SIZE pops, and keeps per-channel counters.
module input_port_cluster_param
  import ipc_pkg::*;
#(
  parameter int PACKET_BITS           = DEF_PACKET_BITS,
  parameter int NUM_LEAF_BITS         = DEF_NUM_LEAF_BITS,
  parameter int NUM_PORT_BITS         = DEF_NUM_PORT_BITS,
  parameter int PAYLOAD_BITS          = 64,
  parameter int NUM_IN_PORTS          = 7,
  parameter int PORT_BASE             = 2,
  parameter int USER_W                = 32,
  parameter int FIFO_DEPTH_BITS       = 7,
  parameter int FREESPACE_UPDATE_SIZE = 64,
  parameter int CNT_BITS              = 32
) (
  input  logic                                                clk,
  input  logic                                                reset,
  input  logic [PACKET_BITS-1:0]                              stream_in,
  input  logic [(NUM_LEAF_BITS+NUM_PORT_BITS)*NUM_IN_PORTS-1:0] in_control_reg,
  input  logic [NUM_IN_PORTS-1:0]                             port_en,
  input  logic                                                is_done_mode,
  output logic [PACKET_BITS*NUM_IN_PORTS-1:0]                 packet_from_input_ports,
  output logic [NUM_IN_PORTS-1:0]                             freespace_update,
  input_port_cluster_param_if.master                          user,
  output logic [CNT_BITS*NUM_IN_PORTS-1:0]                    input_port_full_cnt,
  output logic [CNT_BITS*NUM_IN_PORTS-1:0]                    input_port_empty_cnt,
  output logic [CNT_BITS*NUM_IN_PORTS-1:0]                    input_port_read_cnt,
  output logic [CNT_BITS*NUM_IN_PORTS-1:0]                    input_port_drop_cnt,
  output logic [NUM_IN_PORTS-1:0]                             overflow_err,
  output logic                                                input_port_cluster_stall_condition
);
  localparam int VLD_B  = PACKET_BITS - 1;
  localparam int LEAF_L = VLD_B - NUM_LEAF_BITS;
  localparam int PORT_L = LEAF_L - NUM_PORT_BITS;
  localparam int CW     = NUM_LEAF_BITS + NUM_PORT_BITS;
  localparam int RD_W   = FIFO_DEPTH_BITS + 1;

  logic [NUM_IN_PORTS-1:0]  full, empty, wr_en, pop;
  logic                     pkt_vld;
  logic [NUM_PORT_BITS-1:0] pkt_port;
  logic                     unused_stream;

  assign pkt_vld       = stream_in[VLD_B];
  assign pkt_port      = stream_in[PORT_L +: NUM_PORT_BITS];
  assign unused_stream = ^stream_in;

  assign input_port_cluster_stall_condition = |full;

  for (genvar i = 0; i < NUM_IN_PORTS; i++) begin : g_ch
    logic [USER_W-1:0]      head;
    logic [FIFO_DEPTH_BITS:0] unused_count;
    logic                   hit, drop;
    logic [RD_W-1:0]        rd_since_q;
    logic [CNT_BITS-1:0]    full_cnt_q, empty_cnt_q, read_cnt_q, drop_cnt_q;
    logic                   ovf_q;
    logic [PACKET_BITS-1:0] credit_p1;
    logic                   credit_vld_p1;
    pkt_max_t               credit_full;
    logic                   unused_credit_hi;

    assign hit      = pkt_vld && (pkt_port == NUM_PORT_BITS'(PORT_BASE + i)) && port_en[i];
    assign wr_en[i] = hit && !full[i];
    assign drop     = hit && full[i];
    assign pop[i]   = !empty[i] && user.ack_user2b_in[i];

    ipc_port_fifo #(.W(USER_W), .DEPTH_BITS(FIFO_DEPTH_BITS)) u_fifo (
      .clk     (clk),
      .reset   (reset),
      .wr_en   (wr_en[i]),
      .wr_data (stream_in[USER_W-1:0]),
      .rd_en   (pop[i]),
      .rd_data (head),
      .full    (full[i]),
      .empty   (empty[i]),
      .count   (unused_count)
    );

    // Credit is built from the live control register so a reprogrammed source takes effect at once.
    always_comb begin
      credit_full = build_credit(PACKET_BITS, NUM_LEAF_BITS, NUM_PORT_BITS, PAYLOAD_BITS,
                                 MAX_FIELD_W'(in_control_reg[i*CW+NUM_PORT_BITS +: NUM_LEAF_BITS]),
                                 MAX_FIELD_W'(in_control_reg[i*CW +: NUM_PORT_BITS]),
                                 MAX_CNT_W'(FREESPACE_UPDATE_SIZE));
    end
    assign unused_credit_hi = ^credit_full[MAX_PKT_W-1:PACKET_BITS];

    // p1: credit pulse and counters registered from this cycle's pop/drop/occupancy
    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        rd_since_q    <= '0;
        credit_p1     <= '0;
        credit_vld_p1 <= 1'b0;
        full_cnt_q    <= '0;
        empty_cnt_q   <= '0;
        read_cnt_q    <= '0;
        drop_cnt_q    <= '0;
        ovf_q         <= 1'b0;
      end else begin
        credit_p1     <= '0;
        credit_vld_p1 <= 1'b0;
        if (pop[i]) begin
          if (rd_since_q == RD_W'(FREESPACE_UPDATE_SIZE - 1)) begin
            rd_since_q    <= '0;
            credit_p1     <= credit_full[PACKET_BITS-1:0];
            credit_vld_p1 <= 1'b1;
          end else begin
            rd_since_q <= rd_since_q + 1'b1;
          end
        end
        if (drop) ovf_q <= 1'b1;
        if (!is_done_mode) begin
          if (full[i])  full_cnt_q  <= CNT_BITS'(sat_inc(MAX_CNT_W'(full_cnt_q), CNT_BITS));
          if (empty[i]) empty_cnt_q <= CNT_BITS'(sat_inc(MAX_CNT_W'(empty_cnt_q), CNT_BITS));
          if (pop[i])   read_cnt_q  <= CNT_BITS'(sat_inc(MAX_CNT_W'(read_cnt_q), CNT_BITS));
          if (drop)     drop_cnt_q  <= CNT_BITS'(sat_inc(MAX_CNT_W'(drop_cnt_q), CNT_BITS));
        end
      end
    end

    assign user.vld2user[i]                        = !empty[i];
    assign user.dout2user[i*USER_W +: USER_W]      = empty[i] ? '0 : head;
    assign packet_from_input_ports[i*PACKET_BITS +: PACKET_BITS] = credit_p1;
    assign freespace_update[i]                     = credit_vld_p1;
    assign input_port_full_cnt[i*CNT_BITS +: CNT_BITS]  = full_cnt_q;
    assign input_port_empty_cnt[i*CNT_BITS +: CNT_BITS] = empty_cnt_q;
    assign input_port_read_cnt[i*CNT_BITS +: CNT_BITS]  = read_cnt_q;
    assign input_port_drop_cnt[i*CNT_BITS +: CNT_BITS]  = drop_cnt_q;
    assign overflow_err[i]                         = ovf_q;
  end
endmodule

// File: tb/tb_input_port_cluster_param.sv
// Directed bench for input_port_cluster_param with N=7, D=8, F=4.
module tb_input_port_cluster_param;
  localparam int N  = 7;
  localparam int PB = 97;
  localparam int UW = 32;
  localparam int CB = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset;
  logic [PB-1:0]     stream_in;
  logic [10*N-1:0]   in_control_reg;
  logic [N-1:0]      port_en;
  logic              is_done_mode;
  logic [PB*N-1:0]   pkt_out;
  logic [N-1:0]      fs_upd;
  logic [CB*N-1:0]   full_cnt, empty_cnt, read_cnt, drop_cnt;
  logic [N-1:0]      ovf;
  logic              stall;
  int                checks = 0;
  int                failures = 0;
  logic [31:0]       e0;

  input_port_cluster_param_if #(.N(N), .USER_W(UW)) uif ();

  input_port_cluster_param #(
    .PACKET_BITS(PB), .NUM_LEAF_BITS(6), .NUM_PORT_BITS(4), .PAYLOAD_BITS(64),
    .NUM_IN_PORTS(N), .PORT_BASE(2), .USER_W(UW), .FIFO_DEPTH_BITS(3),
    .FREESPACE_UPDATE_SIZE(4), .CNT_BITS(CB)
  ) dut (
    .clk(clk), .reset(reset), .stream_in(stream_in), .in_control_reg(in_control_reg),
    .port_en(port_en), .is_done_mode(is_done_mode), .packet_from_input_ports(pkt_out),
    .freespace_update(fs_upd), .user(uif.master), .input_port_full_cnt(full_cnt),
    .input_port_empty_cnt(empty_cnt), .input_port_read_cnt(read_cnt),
    .input_port_drop_cnt(drop_cnt), .overflow_err(ovf),
    .input_port_cluster_stall_condition(stall)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [PB-1:0] mkpkt(input logic [5:0] leaf, input logic [3:0] port,
                                          input logic [63:0] pay);
    return {1'b1, leaf, port, 22'd0, pay};
  endfunction

  function automatic logic [31:0] f32(input logic [CB*N-1:0] v, input int ch);
    return v[ch*32 +: 32];
  endfunction

  initial begin
    #200000;
    $display("FAIL timeout checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    stream_in = '0;
    in_control_reg = '0;
    in_control_reg[9:0] = {6'd5, 4'd9};
    port_en = '1;
    is_done_mode = 1'b0;
    uif.ack_user2b_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_vld", uif.vld2user, 0);
    chk("rst_fs", fs_upd, 0);
    chk("rst_stall", stall, 0);
    chk("rst_dout", uif.dout2user, 0);
    chk("rst_ecnt", empty_cnt, 0);
    reset = 1'b1;

    // Three packets to port 3 -> channel 1
    @(negedge clk) stream_in = mkpkt(6'd0, 4'd3, 64'hA);
    @(negedge clk);
    chk("t1_vld", uif.vld2user, 7'b0000010);
    chk("t1_head_a", f32(uif.dout2user, 1), 32'hA);
    stream_in = mkpkt(6'd0, 4'd3, 64'hB);
    @(negedge clk) stream_in = mkpkt(6'd0, 4'd3, 64'hC);
    @(negedge clk) stream_in = '0;
    uif.ack_user2b_in[1] = 1'b1;
    chk("t1_pop_a", f32(uif.dout2user, 1), 32'hA);
    @(negedge clk) chk("t1_pop_b", f32(uif.dout2user, 1), 32'hB);
    @(negedge clk) chk("t1_pop_c", f32(uif.dout2user, 1), 32'hC);
    @(negedge clk) uif.ack_user2b_in[1] = 1'b0;
    chk("t1_empty", uif.vld2user, 0);
    chk("t1_rdcnt", f32(read_cnt, 1), 3);
    chk("t1_nofs", fs_upd, 0);

    // Four pops on channel 0 produce one credit to leaf 5 / port 9
    for (int k = 0; k < 4; k++) begin
      @(negedge clk) stream_in = mkpkt(6'd0, 4'd2, 64'h10 + 64'(k));
    end
    @(negedge clk) stream_in = '0;
    uif.ack_user2b_in[0] = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      if (k == 2) chk("t2_fs_early", fs_upd, 0);
    end
    chk("t2_fs", fs_upd, 7'b0000001);
    chk("t2_pkt", pkt_out[0 +: PB], mkpkt(6'd5, 4'd9, 64'd4));
    uif.ack_user2b_in[0] = 1'b0;
    @(negedge clk);
    chk("t2_fs_off", fs_upd, 0);
    chk("t2_pkt_off", pkt_out[0 +: PB], 0);
    chk("t2_rdcnt", f32(read_cnt, 0), 4);

    // Fill channel 2, overflow with a simultaneous pop
    for (int k = 0; k < 8; k++) begin
      @(negedge clk) stream_in = mkpkt(6'd0, 4'd4, 64'h100 + 64'(k));
    end
    @(negedge clk) stream_in = mkpkt(6'd0, 4'd4, 64'h1FF);
    uif.ack_user2b_in[2] = 1'b1;
    chk("t3_stall", stall, 1);
    chk("t3_head0", f32(uif.dout2user, 2), 32'h100);
    for (int k = 1; k < 8; k++) begin
      @(negedge clk);
      if (k == 1) begin
        stream_in = '0;
        chk("t3_drop", f32(drop_cnt, 2), 1);
        chk("t3_ovf", ovf, 7'b0000100);
        chk("t3_fullcnt", f32(full_cnt, 2), 1);
        chk("t3_stall_off", stall, 0);
      end
      chk($sformatf("t3_word%0d", k), f32(uif.dout2user, 2), 32'h100 + 32'(k));
    end
    @(negedge clk) uif.ack_user2b_in[2] = 1'b0;
    chk("t3_drained", uif.vld2user[2], 0);

    // Disabled channel 3 ignores writes but still drains
    @(negedge clk) stream_in = mkpkt(6'd0, 4'd5, 64'h55);
    @(negedge clk) port_en[3] = 1'b0;
    stream_in = mkpkt(6'd0, 4'd5, 64'h66);
    @(negedge clk) stream_in = mkpkt(6'd0, 4'd5, 64'h77);
    @(negedge clk) stream_in = '0;
    chk("t4_head", f32(uif.dout2user, 3), 32'h55);
    chk("t4_drop", f32(drop_cnt, 3), 0);
    chk("t4_ovf", ovf[3], 0);
    uif.ack_user2b_in[3] = 1'b1;
    @(negedge clk) uif.ack_user2b_in[3] = 1'b0;
    chk("t4_after_pop", uif.vld2user[3], 0);
    port_en[3] = 1'b1;

    // Empty counter on channel 4 runs, then freezes in done mode
    e0 = f32(empty_cnt, 4);
    repeat (10) @(negedge clk);
    chk("t5_ecnt_run", f32(empty_cnt, 4) - e0, 10);
    is_done_mode = 1'b1;
    repeat (10) @(negedge clk);
    chk("t5_ecnt_frz", f32(empty_cnt, 4) - e0, 10);
    is_done_mode = 1'b0;

    // Async reset with channel 0 holding data and a pending pop count of 3
    for (int k = 0; k < 5; k++) begin
      @(negedge clk) stream_in = mkpkt(6'd0, 4'd2, 64'h20 + 64'(k));
    end
    @(negedge clk) stream_in = '0;
    uif.ack_user2b_in[0] = 1'b1;
    repeat (3) @(negedge clk);
    uif.ack_user2b_in[0] = 1'b0;
    chk("t6_pre_vld", uif.vld2user[0], 1);
    #2 reset = 1'b0;
    #1;
    chk("t6_vld", uif.vld2user, 0);
    chk("t6_rdcnt", read_cnt, 0);
    chk("t6_drop", drop_cnt, 0);
    chk("t6_ovf", ovf, 0);
    chk("t6_fcnt", full_cnt, 0);
    @(negedge clk) reset = 1'b1;
    @(negedge clk);
    chk("t6_ecnt1", f32(empty_cnt, 0), 1);
    chk("t6_vld_rel", uif.vld2user, 0);
    stream_in = mkpkt(6'd0, 4'd2, 64'h99);
    @(negedge clk) stream_in = '0;
    uif.ack_user2b_in[0] = 1'b1;
    chk("t6_new_head", f32(uif.dout2user, 0), 32'h99);
    @(negedge clk) uif.ack_user2b_in[0] = 1'b0;
    chk("t6_no_credit", fs_upd, 0);
    chk("t6_rdcnt1", f32(read_cnt, 0), 1);
    @(negedge clk) chk("t6_no_credit2", fs_upd, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
